// File: rtl/fd_skid_latch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : fd_pkg                                                          |
// | Purpose: Shared types and defaults for the fetch/decode skid latch:      |
// |          occupancy state enum, default field widths, default NOP word,   |
// |          and a state-to-occupancy helper.                                |
// | Ports  : none (package)                                                  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package fd_pkg;

  localparam int          DEF_ADDR_W   = 12;
  localparam int          DEF_INSN_W   = 32;
  localparam logic [63:0] DEF_NOP_INSN = 64'h0;

  // Encoding equals the number of entries held, so occupancy is a direct map.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  function automatic logic [1:0] occ_of(input state_t s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      EMPTY:   occ = 2'd0;
      ONE:     occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fd_skid_latch_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : fd_skid_latch_if                                                |
// | Purpose: Bundle of handshake and data signals between fetch, the skid    |
// |          latch and decode.                                               |
// | Ports  : flush, in_valid/in_ready, tg_in/pc_in/pc1_in/ir_in (fetch side) |
// |          out_valid/out_ready, tg_out/pc_out/pc1_out/ir_out, occupancy    |
// |          (decode side).                                                  |
// |          modport master : environment (fetch + decode)                   |
// |          modport slave  : the latch                                      |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
interface fd_skid_latch_if
  import fd_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INSN_W = DEF_INSN_W
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] tg_in;
  logic [ADDR_W-1:0] pc_in;
  logic [ADDR_W-1:0] pc1_in;
  logic [INSN_W-1:0] ir_in;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] tg_out;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W-1:0] pc1_out;
  logic [INSN_W-1:0] ir_out;
  logic [1:0]        occupancy;

  modport master (
    output flush, in_valid, tg_in, pc_in, pc1_in, ir_in, out_ready,
    input  in_ready, out_valid, tg_out, pc_out, pc1_out, ir_out, occupancy
  );

  modport slave (
    input  flush, in_valid, tg_in, pc_in, pc1_in, ir_in, out_ready,
    output in_ready, out_valid, tg_out, pc_out, pc1_out, ir_out, occupancy
  );
endinterface
`default_nettype wire

// File: rtl/fd_skid_latch_entry.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : fd_entry                                                        |
// | Purpose: One bundle storage slot (tg, pc, pc1, ir) with a two-way load   |
// |          source select and a clear that restores the empty value.        |
// | Ports  : clk, clr_n (async active-low reset)                             |
// |          clear   - reset fields to 0 / NOP_INSN (wins over load)         |
// |          load    - capture the selected source                           |
// |          sel_b   - 0: capture *_a, 1: capture *_b                        |
// |          *_a/*_b - candidate bundles; *_q - stored bundle                |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module fd_entry
  import fd_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSN_W   = DEF_INSN_W,
  parameter logic [INSN_W-1:0] NOP_INSN = INSN_W'(DEF_NOP_INSN)
) (
  input  wire logic              clk,
  input  wire logic              clr_n,
  input  wire logic              clear,
  input  wire logic              load,
  input  wire logic              sel_b,
  input  wire logic [ADDR_W-1:0] tg_a,
  input  wire logic [ADDR_W-1:0] pc_a,
  input  wire logic [ADDR_W-1:0] pc1_a,
  input  wire logic [INSN_W-1:0] ir_a,
  input  wire logic [ADDR_W-1:0] tg_b,
  input  wire logic [ADDR_W-1:0] pc_b,
  input  wire logic [ADDR_W-1:0] pc1_b,
  input  wire logic [INSN_W-1:0] ir_b,
  output logic      [ADDR_W-1:0] tg_q,
  output logic      [ADDR_W-1:0] pc_q,
  output logic      [ADDR_W-1:0] pc1_q,
  output logic      [INSN_W-1:0] ir_q
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      tg_q  <= '0;
      pc_q  <= '0;
      pc1_q <= '0;
      ir_q  <= NOP_INSN;
    end else if (clear) begin
      tg_q  <= '0;
      pc_q  <= '0;
      pc1_q <= '0;
      ir_q  <= NOP_INSN;
    end else if (load) begin
      tg_q  <= sel_b ? tg_b  : tg_a;
      pc_q  <= sel_b ? pc_b  : pc_a;
      pc1_q <= sel_b ? pc1_b : pc1_a;
      ir_q  <= sel_b ? ir_b  : ir_a;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fd_skid_latch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : fd_skid_latch                                                   |
// | Purpose: Fetch/decode pipeline latch with valid/ready handshake and a    |
// |          two-entry skid buffer. in_ready is a pure function of the state |
// |          register, so decode's ready never reaches fetch combinationally.|
// | Ports  : clk   - rising-edge clock                                       |
// |          clr_n - asynchronous active-low reset                           |
// |          bus   - fd_skid_latch_if.slave (handshakes, fields, flush,      |
// |                  occupancy)                                              |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module fd_skid_latch
  import fd_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSN_W   = DEF_INSN_W,
  parameter logic [INSN_W-1:0] NOP_INSN = INSN_W'(DEF_NOP_INSN)
) (
  input wire logic     clk,
  input wire logic     clr_n,
  fd_skid_latch_if.slave bus
);

  state_t r_state;
  state_t w_next;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;

  logic w_main_load;
  logic w_main_from_skid;
  logic w_main_clr;
  logic w_skid_load;
  logic w_skid_clr;

  logic [ADDR_W-1:0] w_skid_tg;
  logic [ADDR_W-1:0] w_skid_pc;
  logic [ADDR_W-1:0] w_skid_pc1;
  logic [INSN_W-1:0] w_skid_ir;

  logic [ADDR_W-1:0] w_main_tg;
  logic [ADDR_W-1:0] w_main_pc;
  logic [ADDR_W-1:0] w_main_pc1;
  logic [INSN_W-1:0] w_main_ir;

  assign w_in_ready  = (r_state != FULL);
  assign w_out_valid = (r_state != EMPTY);
  assign w_push      = bus.in_valid & w_in_ready;
  assign w_pop       = w_out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next           = r_state;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_main_clr       = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clr       = 1'b0;

    if (bus.flush) begin
      // A bundle handshaked in this cycle is dropped along with the held ones.
      w_next     = EMPTY;
      w_main_clr = 1'b1;
      w_skid_clr = 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            w_main_load = 1'b1;
            w_next      = ONE;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            w_main_load = 1'b1;
          end else if (w_push) begin
            // Decode stalled: park the new bundle behind the head.
            w_skid_load = 1'b1;
            w_next      = FULL;
          end else if (w_pop) begin
            w_main_clr = 1'b1;
            w_next     = EMPTY;
          end
        end
        FULL: begin
          if (w_pop) begin
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_clr       = 1'b1;
            w_next           = ONE;
          end
        end
        default: begin
          w_next     = EMPTY;
          w_main_clr = 1'b1;
          w_skid_clr = 1'b1;
        end
      endcase
    end
  end

  // Skid only ever captures from fetch, so both of its sources are the input.
  fd_entry #(
    .ADDR_W   (ADDR_W),
    .INSN_W   (INSN_W),
    .NOP_INSN (NOP_INSN)
  ) u_skid (
    .clk   (clk),
    .clr_n (clr_n),
    .clear (w_skid_clr),
    .load  (w_skid_load),
    .sel_b (1'b0),
    .tg_a  (bus.tg_in),
    .pc_a  (bus.pc_in),
    .pc1_a (bus.pc1_in),
    .ir_a  (bus.ir_in),
    .tg_b  (bus.tg_in),
    .pc_b  (bus.pc_in),
    .pc1_b (bus.pc1_in),
    .ir_b  (bus.ir_in),
    .tg_q  (w_skid_tg),
    .pc_q  (w_skid_pc),
    .pc1_q (w_skid_pc1),
    .ir_q  (w_skid_ir)
  );

  fd_entry #(
    .ADDR_W   (ADDR_W),
    .INSN_W   (INSN_W),
    .NOP_INSN (NOP_INSN)
  ) u_main (
    .clk   (clk),
    .clr_n (clr_n),
    .clear (w_main_clr),
    .load  (w_main_load),
    .sel_b (w_main_from_skid),
    .tg_a  (bus.tg_in),
    .pc_a  (bus.pc_in),
    .pc1_a (bus.pc1_in),
    .ir_a  (bus.ir_in),
    .tg_b  (w_skid_tg),
    .pc_b  (w_skid_pc),
    .pc1_b (w_skid_pc1),
    .ir_b  (w_skid_ir),
    .tg_q  (w_main_tg),
    .pc_q  (w_main_pc),
    .pc1_q (w_main_pc1),
    .ir_q  (w_main_ir)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.tg_out    = w_main_tg;
  assign bus.pc_out    = w_main_pc;
  assign bus.pc1_out   = w_main_pc1;
  assign bus.ir_out    = w_main_ir;
  assign bus.occupancy = occ_of(r_state);

endmodule
`default_nettype wire

// File: tb/tb_fd_skid_latch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_fd_skid_latch                                                |
// | Purpose: Directed self-checking bench. Two instances (12/32/NOP=0 and    |
// |          16/64/NOP=0x13) receive identical stimulus; the narrow one sees |
// |          the low bits of each field.                                     |
// | Ports  : none                                                            |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_fd_skid_latch;

  logic clk = 1'b0;
  logic clr_n;

  always #5 clk = ~clk;

  fd_skid_latch_if #(.ADDR_W(12), .INSN_W(32)) ifa ();
  fd_skid_latch_if #(.ADDR_W(16), .INSN_W(64)) ifb ();

  fd_skid_latch #(.ADDR_W(12), .INSN_W(32), .NOP_INSN(32'h0)) u_a (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (ifa.slave)
  );

  fd_skid_latch #(.ADDR_W(16), .INSN_W(64), .NOP_INSN(64'h13)) u_b (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (ifb.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] gen_tg(input logic [15:0] pc);
    return pc ^ 16'hA5C3;
  endfunction

  function automatic logic [63:0] gen_ir(input logic [15:0] pc);
    return {16'hC0DE, pc, 16'hBEEF, ~pc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctl(input logic out_rdy, input logic fl);
    ifa.out_ready = out_rdy; ifb.out_ready = out_rdy;
    ifa.flush     = fl;      ifb.flush     = fl;
  endtask

  task automatic drive(input logic v, input logic [15:0] pc, input logic [15:0] tg,
                       input logic [63:0] ir);
    logic [15:0] pc1;
    pc1 = pc + 16'd1;
    ifa.in_valid = v;         ifb.in_valid = v;
    ifa.pc_in    = pc[11:0];  ifb.pc_in    = pc;
    ifa.tg_in    = tg[11:0];  ifb.tg_in    = tg;
    ifa.pc1_in   = pc1[11:0]; ifb.pc1_in   = pc1;
    ifa.ir_in    = ir[31:0];  ifb.ir_in    = ir;
  endtask

  task automatic push_gen(input logic [15:0] pc);
    drive(1'b1, pc, gen_tg(pc), gen_ir(pc));
  endtask

  task automatic idle_in();
    drive(1'b0, 16'h0, 16'h0, 64'h0);
  endtask

  task automatic exp_rdy(input string tag, input logic r);
    chk({tag, ".a.in_ready"}, 64'(ifa.in_ready), 64'(r));
    chk({tag, ".b.in_ready"}, 64'(ifb.in_ready), 64'(r));
  endtask

  task automatic exp_head(input string tag, input logic [15:0] pc, input logic [15:0] tg,
                          input logic [63:0] ir, input logic [1:0] occ);
    logic [11:0] a_pc1;
    logic [15:0] b_pc1;
    a_pc1 = pc[11:0] + 12'd1;
    b_pc1 = pc + 16'd1;
    chk({tag, ".a.valid"}, 64'(ifa.out_valid), 64'd1);
    chk({tag, ".a.occ"},   64'(ifa.occupancy), 64'(occ));
    chk({tag, ".a.pc"},    64'(ifa.pc_out),    64'(pc[11:0]));
    chk({tag, ".a.tg"},    64'(ifa.tg_out),    64'(tg[11:0]));
    chk({tag, ".a.pc1"},   64'(ifa.pc1_out),   64'(a_pc1));
    chk({tag, ".a.ir"},    64'(ifa.ir_out),    64'(ir[31:0]));
    chk({tag, ".b.valid"}, 64'(ifb.out_valid), 64'd1);
    chk({tag, ".b.occ"},   64'(ifb.occupancy), 64'(occ));
    chk({tag, ".b.pc"},    64'(ifb.pc_out),    64'(pc));
    chk({tag, ".b.tg"},    64'(ifb.tg_out),    64'(tg));
    chk({tag, ".b.pc1"},   64'(ifb.pc1_out),   64'(b_pc1));
    chk({tag, ".b.ir"},    ifb.ir_out,         ir);
  endtask

  task automatic head_gen(input string tag, input logic [15:0] pc, input logic [1:0] occ);
    exp_head(tag, pc, gen_tg(pc), gen_ir(pc), occ);
  endtask

  task automatic exp_empty(input string tag);
    chk({tag, ".a.valid"}, 64'(ifa.out_valid), 64'd0);
    chk({tag, ".a.occ"},   64'(ifa.occupancy), 64'd0);
    chk({tag, ".a.pc"},    64'(ifa.pc_out),    64'd0);
    chk({tag, ".a.tg"},    64'(ifa.tg_out),    64'd0);
    chk({tag, ".a.pc1"},   64'(ifa.pc1_out),   64'd0);
    chk({tag, ".a.ir"},    64'(ifa.ir_out),    64'd0);
    chk({tag, ".b.valid"}, 64'(ifb.out_valid), 64'd0);
    chk({tag, ".b.occ"},   64'(ifb.occupancy), 64'd0);
    chk({tag, ".b.pc"},    64'(ifb.pc_out),    64'd0);
    chk({tag, ".b.tg"},    64'(ifb.tg_out),    64'd0);
    chk({tag, ".b.pc1"},   64'(ifb.pc1_out),   64'd0);
    chk({tag, ".b.ir"},    ifb.ir_out,         64'h13);
    exp_rdy(tag, 1'b1);
  endtask

  initial begin
    clr_n = 1'b0;
    idle_in();
    set_ctl(1'b0, 1'b0);

    // Reset state
    step();
    step();
    exp_empty("reset");
    clr_n = 1'b1;

    // Streaming: one bundle per cycle, each visible one edge after push
    set_ctl(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      push_gen(16'(i));
      step();
      head_gen($sformatf("stream%0d", i), 16'(i), 2'd1);
      exp_rdy($sformatf("stream%0d", i), 1'b1);
    end
    idle_in();
    step();
    exp_empty("stream_drain");

    // Stall: two accepted, third held by fetch, then in-order delivery
    set_ctl(1'b0, 1'b0);
    push_gen(16'h010);
    step();
    head_gen("stall_a", 16'h010, 2'd1);
    exp_rdy("stall_a", 1'b1);
    push_gen(16'h011);
    step();
    head_gen("stall_b", 16'h010, 2'd2);
    exp_rdy("stall_b", 1'b0);
    push_gen(16'h012);
    step();
    head_gen("stall_c", 16'h010, 2'd2);
    exp_rdy("stall_c", 1'b0);
    set_ctl(1'b1, 1'b0);
    step();
    head_gen("stall_d", 16'h011, 2'd1);
    exp_rdy("stall_d", 1'b1);
    step();
    head_gen("stall_e", 16'h012, 2'd1);
    idle_in();
    step();
    exp_empty("stall_drain");

    // Flush while FULL, with fetch presenting 0x020
    set_ctl(1'b0, 1'b0);
    push_gen(16'h030);
    step();
    push_gen(16'h031);
    step();
    head_gen("flfull_pre", 16'h030, 2'd2);
    push_gen(16'h020);
    set_ctl(1'b0, 1'b1);
    step();
    exp_empty("flfull");
    idle_in();
    set_ctl(1'b1, 1'b0);
    step();
    exp_empty("flfull_after");

    // Flush in ONE with a completed handshake: the bundle is discarded
    set_ctl(1'b0, 1'b0);
    push_gen(16'h060);
    step();
    head_gen("flone_pre", 16'h060, 2'd1);
    push_gen(16'h061);
    set_ctl(1'b0, 1'b1);
    step();
    exp_empty("flone");
    idle_in();
    set_ctl(1'b1, 1'b0);
    step();
    exp_empty("flone_after");

    // Drain to empty after a single bundle
    set_ctl(1'b1, 1'b0);
    drive(1'b1, 16'h040, 16'h0AB, 64'hDEADBEEF);
    step();
    exp_head("drain", 16'h040, 16'h0AB, 64'hDEADBEEF, 2'd1);
    idle_in();
    step();
    exp_empty("drain_empty");

    // Asynchronous reset while FULL: outputs clear without a clock edge
    set_ctl(1'b0, 1'b0);
    push_gen(16'h050);
    step();
    push_gen(16'h051);
    step();
    head_gen("arst_pre", 16'h050, 2'd2);
    idle_in();
    #3;
    clr_n = 1'b0;
    #1;
    exp_empty("arst");
    step();
    clr_n = 1'b1;
    set_ctl(1'b1, 1'b0);
    push_gen(16'h070);
    step();
    head_gen("arst_first_push", 16'h070, 2'd1);
    idle_in();
    step();
    exp_empty("arst_end");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fd_skid_latch.md
# fd_skid_latch

Parametrised fetch/decode pipeline latch with a valid/ready handshake and a two-entry skid buffer. It carries the taken-guess address, PC, PC+1 and instruction from fetch to decode at one transfer per cycle under back-pressure. Flush clears all entries in one cycle. It replaces the plain enable/clear fetch/decode register wherever decode can stall without a combinational ready path back to fetch.

## Interface
- ADDR_W, 12, width of TG, PC and PC+1 fields
- INSN_W, 32, instruction width
- NOP_INSN, 0, instruction value presented on `ir_out` when empty, after reset and after flush

- clk  in  1  rising-edge clock
- clr_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous kill of all held entries (mispredict/redirect)
- in_valid  in  1  fetch presents a bundle
- in_ready  out  1  latch can accept; registered, never depends combinationally on out_ready
- tg_in, pc_in, pc1_in  in  ADDR_W each  taken guess, PC, PC+1
- ir_in  in  INSN_W  instruction
- out_valid  out  1  bundle available to decode
- out_ready  in  1  decode consumes
- tg_out, pc_out, pc1_out  out  ADDR_W each  head bundle fields
- ir_out  out  INSN_W  head instruction
- occupancy  out  2  entries held, 0..2

## Operation
- Storage: main entry, which drives the outputs, and skid entry. Each entry holds tg, pc, pc1 and ir.
- Push = in_valid & in_ready; pop = out_valid & out_ready.
- States: EMPTY (occ 0), ONE (main full), FULL (main and skid full).
- in_ready = (state != FULL); out_valid = (state != EMPTY).
- EMPTY: push → main ← in, go to ONE.
- ONE:
  - push & pop → main ← in, stay in ONE.
  - push only → skid ← in, go to FULL.
  - pop only → main ← cleared, go to EMPTY.
- FULL: push impossible. Pop → main ← skid, skid ← cleared, go to ONE.
- Cleared entry: tg, pc and pc1 = 0; ir = NOP_INSN. Outputs are therefore deterministic in EMPTY.
- flush: next state EMPTY and both entries cleared, regardless of push/pop. Flush dominates; a bundle pushed in the same cycle is discarded. Fetch must not count it as delivered, although the handshake completed.
- Bundle order is strictly FIFO; no field is modified in transit.

## Timing
- Reset (clr_n low, asynchronous): state EMPTY, entries cleared. in_ready=1, out_valid=0, occupancy=0, ir_out=NOP_INSN, other outputs 0.
- Reset deassertion is synchronised externally; the first push is accepted on the first clock edge after release.
- Latency: a bundle pushed at edge N is visible on the outputs after edge N when EMPTY, or behind the current head otherwise.
- Throughput: one bundle per cycle while out_ready=1.
- Back-pressure: after out_ready drops, at most one more bundle is accepted (into skid). in_ready falls on the following edge.
- All outputs are registered or derived from state only. There is no in→out or out_ready→in_ready combinational path.
- Reset asserted mid-operation: all state is lost immediately and nothing is replayed.

## Structure
- Shared package `fd_pkg`: state enum {EMPTY, ONE, FULL}, default ADDR_W/INSN_W, and the default NOP_INSN constant.
- Sub-module `fd_entry`: bundle storage with load, load-source select and clear. Instantiated twice (main, skid).
- Top level contains the FSM and handshake logic.

## Test plan
- Reset: clr_n low mid-cycle → outputs immediately out_valid=0, in_ready=1, occupancy=0, ir_out=0.
- Streaming: push pc 0x000..0x009 with out_ready=1 → each bundle appears one cycle later, in order, and in_ready stays 1.
- Stall: out_ready=0 while pushing pc 0x010, 0x011, 0x012 → 0x010 and 0x011 accepted, in_ready=0 from the next cycle, 0x012 held by fetch. Then out_ready=1 → 0x010, 0x011, 0x012 delivered in order.
- Flush while FULL with a simultaneous push of pc 0x020 → next cycle occupancy=0, out_valid=0, ir_out=NOP_INSN; 0x020 is never output.
- Drain to empty: single push (tg=0x0AB, ir=0xDEADBEEF), pop next cycle → EMPTY, and outputs return to 0/NOP.
- Parameter sweep: ADDR_W=16, INSN_W=64, NOP_INSN=0x13 → repeat the streaming and stall scenarios with full-width values; ir_out=0x13 when empty.
